score_digit_renderer: RTL

- Parametrised score renderer for the VGA game HUD: accepts a binary score, converts it to BCD with a sequential double-dabble engine, and holds the digits in a display buffer.
- Maps the current pixel coordinate to an address in an external glyph ROM (10 glyphs, GLYPH_W x GLYPH_H each, 1 bit per pixel).
- Returns a pipelined pixel_on for the colour mux.
- Generalises the fixed four-place digit selector: N digits, glyph size, spacing, leading-zero blanking, and tear-free updates.

---
 rtl/score_digit_renderer_if.sv | 29 ++
 rtl/score_digit_renderer.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/score_digit_renderer_if.sv
// Purpose: bundles the score renderer's score-load, pixel-coordinate and glyph-ROM signals.
// Latency: none, wires only.
// Backpressure: none; busy is a status flag, and loads made while it is high are dropped.
// Ports: value_in/value_load/busy are the score path; pix_x/pix_y/pixel_on are the pixel path;
//        rom_addr/rom_q connect to the external synchronous glyph ROM.
interface score_digit_renderer_if #(
    parameter int VALUE_W    = 14,
    parameter int COORD_W    = 10,
    parameter int ROM_ADDR_W = 14
);
    logic [VALUE_W-1:0]    value_in;
    logic                  value_load;
    logic                  busy;
    logic [COORD_W-1:0]    pix_x;
    logic [COORD_W-1:0]    pix_y;
    logic [ROM_ADDR_W-1:0] rom_addr;
    logic                  rom_q;
    logic                  pixel_on;

    modport master (
        output value_in, value_load, pix_x, pix_y, rom_q,
        input  busy, rom_addr, pixel_on
    );

    modport slave (
        input  value_in, value_load, pix_x, pix_y, rom_q,
        output busy, rom_addr, pixel_on
    );
endinterface

// File: rtl/score_digit_renderer.sv
// Purpose: binary score -> BCD (double dabble) -> display buffer -> glyph ROM address / pixel_on.
// Latency: load to display update VALUE_W+2 cycles; pixel to pixel_on a fixed 3 cycles.
// Backpressure: none; value_load while busy is dropped, and the pixel path accepts every cycle.
// Ports: clk, reset (sync, active high), bus (slave modport: value_in, value_load, busy,
//        pix_x, pix_y, rom_addr, rom_q, pixel_on).
module score_digit_renderer #(
    parameter int NUM_DIGITS = 4,
    parameter int VALUE_W    = 14,
    parameter int GLYPH_W    = 30,
    parameter int GLYPH_H    = 30,
    parameter int GAP        = 2,
    parameter int ORIGIN_X   = 0,
    parameter int ORIGIN_Y   = 0,
    parameter int COORD_W    = 10,
    parameter int ROM_ADDR_W = 14,
    parameter int LZ_BLANK   = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    score_digit_renderer_if.slave bus
);

    localparam int BCD_W = 4 * NUM_DIGITS;
    localparam int SR_W  = BCD_W + VALUE_W;
    localparam int CNT_W = $clog2(VALUE_W + 1);

    function automatic longint unsigned pow10(input int n);
        longint unsigned p;
        p = 1;
        for (int i = 0; i < n; i++) p = p * 10;
        return p;
    endfunction

    localparam longint unsigned MAX_VAL = pow10(NUM_DIGITS) - 1;
    localparam logic [ROM_ADDR_W-1:0] GLYPH_SZ = ROM_ADDR_W'(GLYPH_W * GLYPH_H);

    // Left column of digit cell k; cells are placed at a fixed pitch of GLYPH_W+GAP.
    function automatic logic [31:0] cell_x(input int k);
        return 32'(ORIGIN_X + k * (GLYPH_W + GAP));
    endfunction

    // ---------------- conversion FSM ----------------
    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

    state_t             state, state_next;
    logic               accept, commit;
    logic               busy_q;
    logic [CNT_W-1:0]   cnt;
    logic [SR_W-1:0]    sreg, sreg_adj;
    logic [VALUE_W-1:0] cap;
    logic [3:0]         disp [NUM_DIGITS];

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        commit     = 1'b0;
        case (state)
            IDLE: begin
                // busy_q lingers one cycle past COMMIT, and loads in that cycle are dropped too.
                if (bus.value_load && !busy_q) begin
                    accept     = 1'b1;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt == CNT_W'(VALUE_W - 1)) state_next = COMMIT;
            end
            COMMIT: begin
                commit     = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Values that cannot be shown saturate to all nines.
    always_comb begin
        cap = bus.value_in;
        if (64'(bus.value_in) > MAX_VAL) cap = VALUE_W'(MAX_VAL);
    end

    // Double-dabble correction: any BCD nibble >= 5 gets +3 before the shift.
    always_comb begin
        sreg_adj = sreg;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (sreg[VALUE_W + 4*i +: 4] >= 4'd5)
                sreg_adj[VALUE_W + 4*i +: 4] = sreg[VALUE_W + 4*i +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q <= 1'b0;
            cnt    <= '0;
            sreg   <= '0;
            for (int k = 0; k < NUM_DIGITS; k++) disp[k] <= 4'd0;
        end else begin
            busy_q <= accept || (state != IDLE);
            if (accept) begin
                sreg <= {{BCD_W{1'b0}}, cap};
                cnt  <= '0;
            end else if (state == SHIFT) begin
                sreg <= sreg_adj << 1;
                cnt  <= cnt + 1'b1;
            end
            // The display only changes here, so a frame never mixes old and new digits.
            if (commit) begin
                for (int k = 0; k < NUM_DIGITS; k++)
                    disp[k] <= sreg[VALUE_W + 4*(NUM_DIGITS-1-k) +: 4];
            end
        end
    end

    assign bus.busy = busy_q;

    // ---------------- pixel pipeline, stage 0 ----------------
    logic [31:0]           xi, yi, row, col, xoff;
    logic                  hit, in_box, lead_zero, blank_sel;
    logic [3:0]            dig;
    logic [ROM_ADDR_W-1:0] addr_next;

    // Offsets use unsigned wrap: a coordinate left of/above the origin becomes huge and fails the bound.
    always_comb begin
        xi        = 32'(bus.pix_x);
        yi        = 32'(bus.pix_y);
        row       = yi - 32'(ORIGIN_Y);
        hit       = 1'b0;
        col       = '0;
        xoff      = '0;
        dig       = 4'd0;
        lead_zero = 1'b1;
        blank_sel = 1'b0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            lead_zero = lead_zero && (disp[k] == 4'd0);
            xoff      = xi - cell_x(k);
            if (xoff < 32'(GLYPH_W)) begin
                hit       = 1'b1;
                col       = xoff;
                dig       = disp[k];
                blank_sel = (LZ_BLANK != 0) && (k != NUM_DIGITS - 1) && lead_zero;
            end
        end
        in_box    = hit && (row < 32'(GLYPH_H));
        addr_next = ROM_ADDR_W'(dig) * GLYPH_SZ
                  + ROM_ADDR_W'(row) * ROM_ADDR_W'(GLYPH_W)
                  + ROM_ADDR_W'(col);
    end

    // ---------------- stages 1..3 ----------------
    logic [ROM_ADDR_W-1:0] rom_addr_q;
    logic                  vis_d1, vis_d2, pixel_on_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            rom_addr_q <= '0;
            vis_d1     <= 1'b0;
            vis_d2     <= 1'b0;
            pixel_on_q <= 1'b0;
        end else begin
            if (in_box) rom_addr_q <= addr_next;
            vis_d1     <= in_box && !blank_sel;
            vis_d2     <= vis_d1;
            pixel_on_q <= bus.rom_q && vis_d2;
        end
    end

    assign bus.rom_addr = rom_addr_q;
    assign bus.pixel_on = pixel_on_q;

endmodule
